// File: rtl/systolic_host_sequencer.sv
// Host-side sequencer for the systolic accelerator: loads A then B rows, kicks a job,
// waits for a qualified done (with timeout) and streams the N result rows out.
module systolic_host_sequencer #(
    parameter int ARRAY_SIZE     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int ADDR_WIDTH     = $clog2(ARRAY_SIZE),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  out_data,
    output logic                                  out_last,
    output logic                                  acc_wr_en_a,
    output logic                                  acc_wr_en_b,
    output logic [ADDR_WIDTH-1:0]                 acc_wr_row_addr,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] acc_wr_data,
    output logic                                  acc_start,
    input  logic                                  acc_busy,
    input  logic                                  acc_done,
    output logic [ADDR_WIDTH-1:0]                 acc_rd_row_addr,
    input  logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  acc_rd_data,
    output logic                                  seq_busy,
    output logic                                  err,
    input  logic                                  err_clr,
    output logic [2:0]                            dbg_state
);

    // Streams: a beat transfers on a clock edge where valid && ready; the source holds
    // data stable while valid is high and ready is low.

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_KICK   = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ARRAY_SIZE - 1);
    localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] row_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [TW-1:0]         to_cnt;
    logic                  seen_busy;

    logic load_hs;
    logic last_row;
    logic done_ok;
    logic timeout_hit;
    logic capture;
    logic drain_end;

    always_comb begin
        in_ready    = (state == S_LOAD_A) || (state == S_LOAD_B);
        load_hs     = in_valid && in_ready;
        last_row    = (row_cnt == LAST_ROW);
        // A done is only trusted once this job has shown busy; a stale level is ignored.
        done_ok     = (state == S_WAIT) && acc_done && seen_busy;
        timeout_hit = (state == S_WAIT) && !done_ok && (to_cnt == TO_LAST);
        drain_end   = (state == S_DRAIN) && out_valid && out_ready && out_last;
        // Row 0 is captured in the done cycle so the first beat appears one cycle later.
        capture     = done_ok ||
                      ((state == S_DRAIN) && (!out_valid || out_ready) && !(out_valid && out_last));
        seq_busy    = !((state == S_LOAD_A) && (row_cnt == '0));
        dbg_state   = state;
        acc_rd_row_addr = rd_ptr;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD_A: if (load_hs && last_row) state_nxt = S_LOAD_B;
            S_LOAD_B: if (load_hs && last_row) state_nxt = S_KICK;
            S_KICK:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_ok)          state_nxt = S_DRAIN;
                else if (timeout_hit) state_nxt = S_LOAD_A;
            end
            S_DRAIN:  if (drain_end) state_nxt = S_LOAD_A;
            default:  state_nxt = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD_A;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt         <= '0;
            rd_ptr          <= '0;
            to_cnt          <= '0;
            seen_busy       <= 1'b0;
            acc_wr_en_a     <= 1'b0;
            acc_wr_en_b     <= 1'b0;
            acc_wr_row_addr <= '0;
            acc_wr_data     <= '0;
            acc_start       <= 1'b0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            out_data        <= '0;
            err             <= 1'b0;
        end else begin
            acc_wr_en_a <= load_hs && (state == S_LOAD_A);
            acc_wr_en_b <= load_hs && (state == S_LOAD_B);
            acc_start   <= (state == S_KICK);

            if (load_hs) begin
                acc_wr_data     <= in_data;
                acc_wr_row_addr <= row_cnt;
                row_cnt         <= last_row ? '0 : row_cnt + ADDR_WIDTH'(1);
            end

            // Counter is zero in the acc_start cycle, i.e. the first WAIT cycle.
            if (state == S_KICK) begin
                to_cnt    <= '0;
                seen_busy <= 1'b0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + TW'(1);
                if (acc_busy) seen_busy <= 1'b1;
            end

            if (timeout_hit)  err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            if (capture) begin
                out_data  <= acc_rd_data;
                out_valid <= 1'b1;
                out_last  <= (rd_ptr == LAST_ROW);
                if (rd_ptr != LAST_ROW) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end else if (drain_end) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_ptr    <= '0;
            end
        end
    end

endmodule

// File: doc/systolic_host_sequencer.md
# systolic_host_sequencer

Host-side initiator for the systolic matrix-multiply accelerator's load/start/read interface. It accepts matrix rows on a valid/ready input stream and writes A and then B into the accelerator's register files. It then pulses start, waits for completion, and streams the N result rows out on a valid/ready output stream. It sits between the system DMA/stream fabric and the accelerator top, and runs back-to-back jobs with no software involvement.

## Interface
- ARRAY_SIZE, 4, matrix dimension N
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 32, signed result width
- ADDR_WIDTH, $clog2(ARRAY_SIZE), row address width
- TIMEOUT_CYCLES, 1024, maximum cycles from start to done before the job is aborted
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid is also high
- in_data  in  DATA_WIDTH x ARRAY_SIZE  one signed matrix row; N rows of A, then N rows of B
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts the result row
- out_data  out  ACC_WIDTH x ARRAY_SIZE  signed result row C[r]
- out_last  out  1  high with row N-1
- acc_wr_en_a / acc_wr_en_b  out  1 each  accelerator A/B row write strobes
- acc_wr_row_addr  out  ADDR_WIDTH  accelerator write row address
- acc_wr_data  out  DATA_WIDTH x ARRAY_SIZE  accelerator write row data
- acc_start  out  1  single-cycle start pulse
- acc_busy, acc_done  in  1 each  accelerator status
- acc_rd_row_addr  out  ADDR_WIDTH  accelerator result row select
- acc_rd_data  in  ACC_WIDTH x ARRAY_SIZE  accelerator result row, combinational from acc_rd_row_addr
- seq_busy  out  1  high whenever the sequencer is not in LOAD_A with row_cnt==0
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

## Operation
- States: LOAD_A, LOAD_B, KICK, WAIT, DRAIN. The reset state is LOAD_A with row_cnt=0.
- in_ready = (state==LOAD_A || state==LOAD_B), decoded combinationally. in_valid is ignored in all other states.
- LOAD_A / LOAD_B:
  - Each handshake registers in_data into acc_wr_data and row_cnt into acc_wr_row_addr.
  - The matching write strobe is asserted for exactly 1 cycle.
  - row_cnt increments on each handshake. After row N-1 it wraps to 0 and the state advances: LOAD_A->LOAD_B, LOAD_B->KICK.
- KICK: lasts 1 cycle, then moves to WAIT. acc_start is registered and goes high for exactly one cycle on WAIT entry.
- WAIT:
  - The timeout counter starts at 0 in the acc_start cycle.
  - A seen_busy flag is set when acc_busy is sampled high. acc_done is ignored until seen_busy is set, so a stale done from the previous job is never used.
  - acc_done high with seen_busy set -> DRAIN. A single-cycle done pulse and a held done level both qualify.
  - Counter reaches TIMEOUT_CYCLES-1 without qualifying done -> err=1, return to LOAD_A, no output rows.
- DRAIN:
  - rd_ptr (0..N-1, registered) drives acc_rd_row_addr.
  - When !out_valid || out_ready: capture acc_rd_data into out_data, set out_valid=1, set out_last=(rd_ptr==N-1), and increment rd_ptr if rd_ptr<N-1.
  - The handshake of the out_last row clears out_valid and returns the state to LOAD_A.
- err is set by timeout and cleared by err_clr. Simultaneous set and clear: set wins.
- No arithmetic is performed on data. Operands and results pass through bit-exact; rows are never reordered or dropped.

## Timing
- Reset values:
  - State and counters: state=LOAD_A, row_cnt=0, rd_ptr=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, all acc_* outputs 0, seq_busy=0, err=0.
  - Reset mid-job aborts immediately; a partially loaded job is discarded.
- Write latency: handshake at cycle t -> strobe at t+1.
- Start latency: last B handshake at cycle t -> acc_wr_en_b at t+1 (state KICK) -> acc_start at t+2. Start never coincides with a write.
- First out_valid: the cycle after the qualifying done is sampled. With out_ready held high, the N rows appear on N consecutive cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and rd_ptr does not advance.
- Next job: in_ready=1 the cycle after the out_last handshake. Zero-gap input gives N rows per N cycles per matrix.

## Test plan
- A = identity, B rows {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4},{0,0,0,127}, N=4, out_ready=1 -> 4 output rows equal B, out_last on row 3 only, in_ready returns to 1.
- in_valid with random 0–3 cycle bubbles -> exactly 4 acc_wr_en_a then 4 acc_wr_en_b pulses with addresses 0,1,2,3 each. acc_start is a single pulse 2 cycles after the last B handshake.
- out_ready toggling 1,0,0,1 -> out_data stable while stalled, rows 0..3 each delivered once, in order.
- All A = -128, all B = -128 -> every C element = 65536 (0x00010000).
- Accelerator stub never asserts done, TIMEOUT_CYCLES=16 -> err=1 16 cycles after acc_start, no out_valid, state LOAD_A. err_clr -> err=0. The next job completes normally.
- rst_n asserted mid-DRAIN (after row 1 accepted) -> out_valid=0 and in_ready=1 immediately. A following full job produces correct results with no stale rows.
